// File: rtl/pattern_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package pattern_det_pkg;

   localparam int DEFAULT_MAX_LEN = 8;
   localparam int DEFAULT_CNT_W   = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pattern_detector_param_sat_counter.sv
// Saturating up-counter; clr wins over the old value, not over inc.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? W'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pattern_detector_param.sv
// Serial pattern detector with runtime pattern/length load,
// optional overlap and a saturating match counter.
module pattern_detector_param
   import pattern_det_pkg::*;
#(
   parameter int MAX_LEN = DEFAULT_MAX_LEN,
   parameter int CNT_W   = DEFAULT_CNT_W,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic               data_i,
   input  logic               cfg_we_i,
   input  logic [MAX_LEN-1:0] cfg_pattern_i,
   input  logic [LEN_W-1:0]   cfg_len_i,
   input  logic               overlap_i,
   input  logic               cnt_clr_i,
   output logic               pattern_o,
   output logic [CNT_W-1:0]   match_cnt_o,
   output logic               armed_o,
   output logic               cfg_err_o
);

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   state_t             state_q;
   state_t             state_d;
   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_nxt;
   logic               cfg_ok;
   logic               shift;
   logic               match;

   assign cfg_ok   = (cfg_len_i != '0) && (cfg_len_i <= MAX_L);
   assign shift    = (state_q == RUN) && valid_i && !cfg_we_i;
   assign hist_nxt = {hist_q[MAX_LEN-2:0], data_i};
   assign fill_nxt = (fill_q == MAX_L) ? fill_q
                                       : fill_q + LEN_W'(1);

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
   end

   // Compare only the low len bits of the post-shift history.
   assign match = shift && (fill_nxt >= len_q) &&
                  (((hist_nxt ^ pat_q) & mask) == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cfg_we_i) state_d = cfg_ok ? RUN : IDLE;
   end

   always_comb begin
      armed_o = (state_q == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         pattern_o <= 1'b0;
         cfg_err_o <= 1'b0;
      end else begin
         pattern_o <= 1'b0;
         cfg_err_o <= 1'b0;
         if (cfg_we_i) begin
            hist_q <= '0;
            fill_q <= '0;
            if (cfg_ok) begin
               pat_q <= cfg_pattern_i;
               len_q <= cfg_len_i;
            end else begin
               cfg_err_o <= 1'b1;
            end
         end else if (shift) begin
            hist_q    <= hist_nxt;
            fill_q    <= (match && !overlap_i) ? '0 : fill_nxt;
            pattern_o <= match;
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (match),
      .clr  (cnt_clr_i),
      .count(match_cnt_o)
   );

endmodule
